// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types for the I/D memory port arbiter: FSM state,
//               requester identity, latched memory command and the
//               round-robin tie-break helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Storage widths of the latched command. Arbiter ADDR_W / DATA_W must not
    // exceed these; narrower instances simply leave the upper bits at zero.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    localparam int CMD_BE_W   = CMD_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    typedef enum logic [0:0] {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_BE_W-1:0]   be;
        logic                  we;
    } mem_cmd_t;

    // Pick the requester to grant: a lone requester wins outright, a tie goes
    // to whichever side was not granted last.
    function automatic requester_t rr_pick(input logic       req_i,
                                           input logic       req_d,
                                           input requester_t last);
        requester_t pick;
        if (req_i && req_d) begin
            pick = (last == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            pick = REQ_D;
        end else begin
            pick = REQ_I;
        end
        return pick;
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_timeout.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_counter
// Description : Wait-state counter for an outstanding memory access. expired
//               is high during the TIMEOUT-th enabled cycle after a clear.
//               TIMEOUT = 0 removes the counter and never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int               CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Count enabled cycles, saturating at the last allowed count
            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (enable && (cnt_q != LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Counter register, asynchronously cleared by reset
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = enable && (cnt_q == LAST);
        end else begin : g_no_timeout
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clear, enable};
            assign expired       = 1'b0;
        end
    endgenerate

endmodule : mem_timeout_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates one single-ported memory bus between the
//               instruction-fetch (I) and load/store (D) requesters with
//               round-robin tie-breaking, registered memory-side signals,
//               a wait-state timeout and a combinational stall output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch requester
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    output logic                i_err,
    // load/store requester
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    // shared memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    // control unit
    output logic                stall,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t  state_q,      state_d;
    requester_t  last_grant_q, last_grant_d;
    requester_t  grant_q,      grant_d;
    mem_cmd_t    cmd_q,        cmd_d;
    logic        mem_req_q,    mem_req_d;
    logic        i_ack_q,      i_ack_d;
    logic        i_err_q,      i_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic        d_ack_q,      d_ack_d;
    logic        d_err_q,      d_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic        w_expired;
    logic        w_any_req;
    requester_t  w_pick;

    assign w_any_req = i_req | d_req;
    assign w_pick    = rr_pick(i_req, d_req, last_grant_q);

    // Wait-state counter: held at zero while idle, counts each ISSUE cycle
    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ARB_IDLE),
        .enable  (state_q == ARB_ISSUE),
        .expired (w_expired)
    );

    // State register and all datapath flops; reset abandons any access at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= REQ_I;
            grant_q      <= REQ_I;
            cmd_q        <= '0;
            mem_req_q    <= 1'b0;
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cmd_q        <= cmd_d;
            mem_req_q    <= mem_req_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            i_rdata_q    <= i_rdata_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Next-state logic: IDLE -> ISSUE on any request, ISSUE -> RESP on ack or
    // timeout, RESP always returns to IDLE after one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (w_any_req)             state_d = ARB_ISSUE;
            ARB_ISSUE: if (mem_ack || w_expired)  state_d = ARB_RESP;
            ARB_RESP:                             state_d = ARB_IDLE;
            default:                              state_d = ARB_IDLE;
        endcase
    end

    // Output/datapath logic: latch the command on grant, hold it through
    // ISSUE, and turn completion or timeout into a one-cycle ack/err
    always_comb begin
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cmd_d        = cmd_q;
        mem_req_d    = 1'b0;
        i_ack_d      = 1'b0;
        i_err_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (w_any_req) begin
                    grant_d      = w_pick;
                    last_grant_d = w_pick;
                    mem_req_d    = 1'b1;
                    if (w_pick == REQ_D) begin
                        cmd_d.addr  = CMD_ADDR_W'(d_addr);
                        cmd_d.wdata = CMD_DATA_W'(d_wdata);
                        cmd_d.be    = CMD_BE_W'(d_be);
                        cmd_d.we    = d_we;
                    end else begin
                        // fetches are always full-word reads
                        cmd_d.addr  = CMD_ADDR_W'(i_addr);
                        cmd_d.wdata = '0;
                        cmd_d.be    = CMD_BE_W'({BE_W{1'b1}});
                        cmd_d.we    = 1'b0;
                    end
                end
            end
            ARB_ISSUE: begin
                if (mem_ack) begin
                    // a real completion takes priority over a same-cycle timeout
                    if (grant_q == REQ_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rdata;
                    end
                end else if (w_expired) begin
                    if (grant_q == REQ_D) begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b1;
                    end else begin
                        i_ack_d = 1'b1;
                        i_err_d = 1'b1;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                // RESP: requests are deliberately not sampled here
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr[ADDR_W-1:0];
    assign mem_wdata = cmd_q.wdata[DATA_W-1:0];
    assign mem_be    = cmd_q.be[BE_W-1:0];

    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

    // Control unit freezes in the very cycle a request is raised
    assign stall = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);
    assign busy  = (state_q != ARB_IDLE);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter
//               (TIMEOUT = 4). Inputs change 1ns after the rising edge and
//               outputs are sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack, i_err;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [3:0]        d_be = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack, d_err;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              stall, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
            n_fail++; $display("FAIL reset_mem: got %h required 0", {mem_req, mem_we, mem_addr, mem_wdata, mem_be});
        end
        n_cmp++;
        if ({i_ack, i_err, d_ack, d_err, i_rdata, d_rdata, busy, stall} !== '0) begin
            n_fail++; $display("FAIL reset_resp: got %h required 0", {i_ack, i_err, d_ack, d_err, i_rdata, d_rdata, busy, stall});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        int ack_cnt;
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        n_cmp++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL fetch_c0 stall/mem_req: got %b%b required 10", stall, mem_req);
        end
        tick();                                // cycle 1: ISSUE
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF || stall !== 1'b1) begin
            n_fail++; $display("FAIL fetch_c1 req/addr/we/be/stall: got %b %h %b %h %b required 1 100 0 f 1",
                               mem_req, mem_addr, mem_we, mem_be, stall);
        end
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();                                // cycle 2: RESP
        mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        n_cmp++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h00500093 || i_err !== 1'b0 || d_ack !== 1'b0) begin
            n_fail++; $display("FAIL fetch_c2 ack/rdata/err/d_ack: got %b %h %b %b required 1 00500093 0 0",
                               i_ack, i_rdata, i_err, d_ack);
        end
        n_cmp++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL fetch_c2 stall/mem_req: got %b%b required 00", stall, mem_req);
        end
        ack_cnt = 1;
        i_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (i_ack === 1'b1) ack_cnt++;
        end
        n_cmp++;
        if (ack_cnt != 1 || busy !== 1'b0 || i_rdata !== 32'h00500093) begin
            n_fail++; $display("FAIL fetch_after acks/busy/rdata: got %0d %b %h required 1 0 00500093", ack_cnt, busy, i_rdata);
        end
    endtask

    task automatic test_store_wait();
        int d_acks = 0;
        int i_acks = 0;
        int bad    = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        tick();                                // first ISSUE cycle
        // scramble requester inputs: they must not leak after the grant
        d_addr = 32'hAAAA_AAAA; d_wdata = 32'h0; d_be = 4'hC; d_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2004 ||
                mem_wdata !== 32'hDEADBEEF || mem_be !== 4'b0011) bad++;
            if (k == 2) mem_ack = 1'b1;
            tick();
            if (d_ack === 1'b1) d_acks++;
            if (i_ack === 1'b1) i_acks++;
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL store_stable: got %0d unstable cycles required 0", bad);
        end
        n_cmp++;
        if (d_ack !== 1'b1 || d_err !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL store_resp ack/err/mem_req: got %b%b%b required 100", d_ack, d_err, mem_req);
        end
        d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (d_ack === 1'b1) d_acks++;
            if (i_ack === 1'b1) i_acks++;
        end
        n_cmp++;
        if (d_acks != 1 || i_acks != 0) begin
            n_fail++; $display("FAIL store_pulses d/i: got %0d %0d required 1 0", d_acks, i_acks);
        end
    endtask

    task automatic test_simultaneous();
        logic [ADDR_W-1:0] exp_addr [3];
        logic              exp_d    [3];
        exp_addr[0] = 32'h3000; exp_d[0] = 1'b1;
        exp_addr[1] = 32'h0200; exp_d[1] = 1'b0;
        exp_addr[2] = 32'h3000; exp_d[2] = 1'b1;
        do_reset();
        d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF; i_addr = 32'h200;
        i_req = 1'b1; d_req = 1'b1;
        for (int g = 0; g < 3; g++) begin
            tick();                            // ISSUE
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr[g]) begin
                n_fail++; $display("FAIL tie_grant%0d req/addr: got %b %h required 1 %h", g, mem_req, mem_addr, exp_addr[g]);
            end
            mem_ack = 1'b1; mem_rdata = 32'h11 * (g + 1);
            tick();                            // RESP
            mem_ack = 1'b0;
            n_cmp++;
            if (d_ack !== exp_d[g] || i_ack !== !exp_d[g] || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL tie_resp%0d d_ack/i_ack/mem_req: got %b%b%b required %b%b0",
                                   g, d_ack, i_ack, mem_req, exp_d[g], !exp_d[g]);
            end
            tick();                            // IDLE, ack must already be gone
            n_cmp++;
            if (d_ack !== 1'b0 || i_ack !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL tie_idle%0d d_ack/i_ack/mem_req: got %b%b%b required 000", g, d_ack, i_ack, mem_req);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        n_cmp++;
        if (d_rdata !== 32'h33 || i_rdata !== 32'h22) begin
            n_fail++; $display("FAIL tie_rdata d/i: got %h %h required 00000033 00000022", d_rdata, i_rdata);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        for (int k = 0; k < 8 && d_ack !== 1'b1; k++) begin
            tick();
            if (mem_req === 1'b1) req_cycles++;
            mem_rdata = 32'hBAD0_0000 + k;     // must never be captured
        end
        n_cmp++;
        if (req_cycles != 4) begin
            n_fail++; $display("FAIL timeout_req_cycles: got %0d required 4", req_cycles);
        end
        n_cmp++;
        if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h33 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_resp ack/err/rdata/mem_req: got %b %b %h %b required 1 1 00000033 0",
                               d_ack, d_err, d_rdata, mem_req);
        end
        d_req = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || d_ack !== 1'b0 || d_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle busy/ack/err: got %b%b%b required 000", busy, d_ack, d_err);
        end
    endtask

    task automatic test_ack_timeout_coincide();
        d_req = 1'b1; d_addr = 32'h4004;
        tick(); tick(); tick(); tick();        // 4th ISSUE cycle
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL coincide_req4: got %b required 1", mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h5555_AAAA) begin
            n_fail++; $display("FAIL coincide_resp ack/err/rdata: got %b %b %h required 1 0 5555aaaa", d_ack, d_err, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick(); tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (i_ack !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b0 || d_rdata !== 32'h5555_AAAA || i_rdata !== 32'h22) begin
            n_fail++; $display("FAIL stray_ack i_ack/d_ack/busy/d_rdata/i_rdata: got %b %b %b %h %h required 0 0 0 5555aaaa 00000022",
                               i_ack, d_ack, busy, d_rdata, i_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks = 0;
        i_req = 1'b1; i_addr = 32'h800;
        tick();                                // ISSUE
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL midrst_issue: got %b required 1", mem_req);
        end
        #2 rst = 1'b0;                         // well away from any clock edge
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async mem_req/busy: got %b%b required 00", mem_req, busy);
        end
        i_req = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (i_ack === 1'b1 || d_ack === 1'b1) acks++;
        end
        n_cmp++;
        if (acks != 0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after acks/busy/mem_req: got %0d %b %b required 0 0 0", acks, busy, mem_req);
        end
        i_req = 1'b1; i_addr = 32'h900; d_req = 1'b1; d_addr = 32'h5000; d_we = 1'b1;
        tick();
        n_cmp++;
        if (mem_addr !== 32'h5000 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL midrst_tie addr/we: got %h %b required 00005000 1", mem_addr, mem_we);
        end
        i_req = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_simultaneous();
        test_timeout();
        test_ack_timeout_coincide();
        test_stray_ack();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // absolute time bound so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
